// File: rtl/fns_pkg.sv
// Shared FNS definitions: weight function, width limit and controller state encoding.
// Used by the encoder and the FNS codeword decoders so the weight series is defined once.
package fns_pkg;

  localparam int unsigned FNS_MAX_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } fns_state_e;

  // Weight of codebit k: W[0]=1, W[1]=2, W[k]=W[k-1]+W[k-2].
  function automatic int unsigned fns_weight(input int unsigned k);
    int unsigned a;
    int unsigned b;
    int unsigned c;
    a = 1;
    b = 2;
    if (k == 0) return 1;
    for (int unsigned i = 2; i <= k; i++) begin
      c = a + b;
      a = b;
      b = c;
    end
    return b;
  endfunction

endpackage

// File: rtl/fns_weight_rom.sv
// Combinational lookup of the FNS weight W[idx] for codebit positions 0..CW-1.
module fns_weight_rom
  import fns_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 6,
  parameter int unsigned IW = 3
) (
  input  logic [IW-1:0] idx_i,
  output logic [DW-1:0] w_o
);

  logic [DW-1:0] rom [CW];

  // Constant table built at elaboration from the shared weight function.
  for (genvar k = 0; k < CW; k++) begin : g_rom
    assign rom[k] = DW'(fns_weight(k));
  end

  // Select the entry matching idx; indices beyond CW-1 read as zero.
  always_comb begin
    w_o = '0;
    for (int unsigned k = 0; k < CW; k++) begin
      if (idx_i == IW'(k)) w_o = rom[k];
    end
  end

endmodule

// File: rtl/fns_cac_enc_seq.sv
// Sequential FNS crosstalk-avoidance encoder: binary word -> CW-bit Fibonacci codeword.
// Greedy MSB-first conversion, one codebit per cycle, valid/ready on input and output.
// Optional range check enabled by defining FNS_ENC_RANGE_CHK_EN (adds the out_err port).
module fns_cac_enc_seq
  import fns_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code
`ifdef FNS_ENC_RANGE_CHK_EN
  ,
  output logic          out_err
`endif
);

  localparam int unsigned IW = $clog2(CW);
  localparam int unsigned RW = DW + 1;

  // Elaboration-time sanity of the parameter pair.
  if (CW < 3 || CW > FNS_MAX_CW) begin : g_cw_bad
    $error("fns_cac_enc_seq: CW=%0d outside 3..%0d", CW, FNS_MAX_CW);
  end
  if (DW != $clog2(fns_weight(CW))) begin : g_dw_bad
    $error("fns_cac_enc_seq: DW=%0d must equal clog2(W[CW])=%0d", DW, $clog2(fns_weight(CW)));
  end

  fns_state_e    state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] code_q, code_d;
  logic [CW-1:0] out_code_q, out_code_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [DW-1:0] w_cur;
  logic          take_bit;
`ifdef FNS_ENC_RANGE_CHK_EN
  localparam int unsigned WTOP = fns_weight(CW);
  logic          err_q, err_d;
  logic          out_err_q, out_err_d;
`endif

  fns_weight_rom #(
    .CW (CW),
    .DW (DW),
    .IW (IW)
  ) u_weight_rom (
    .idx_i (idx_q),
    .w_o   (w_cur)
  );

  // Greedy decision for the current codebit.
`ifdef FNS_ENC_RANGE_CHK_EN
  assign take_bit = !err_q && (rem_q >= RW'(w_cur));
`else
  assign take_bit = rem_q >= RW'(w_cur);
`endif

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    code_d      = code_q;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef FNS_ENC_RANGE_CHK_EN
    err_d       = err_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          rem_d      = RW'(in_data);
          idx_d      = IW'(CW - 1);
          code_d     = '0;
          in_ready_d = 1'b0;
          state_d    = CONV;
`ifdef FNS_ENC_RANGE_CHK_EN
          err_d      = (32'(in_data) >= WTOP);
          out_err_d  = 1'b0;
`endif
        end
      end
      CONV: begin
        in_ready_d    = 1'b0;
        code_d[idx_q] = take_bit;
        if (take_bit) rem_d = rem_q - RW'(w_cur);
        if (idx_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_code_d  = code_d;
`ifdef FNS_ENC_RANGE_CHK_EN
          out_err_d   = err_q;
`endif
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        in_ready_d = 1'b0;
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      idx_q       <= '0;
      code_q      <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef FNS_ENC_RANGE_CHK_EN
      err_q       <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef FNS_ENC_RANGE_CHK_EN
      err_q       <= err_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
`ifdef FNS_ENC_RANGE_CHK_EN
  assign out_err   = out_err_q;
`endif

endmodule

// File: tb/tb_fns_cac_enc_seq.sv
// Directed bench for fns_cac_enc_seq (CW=8, DW=6) with an expected-code scoreboard.
module tb_fns_cac_enc_seq;

  localparam int CW = 8;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_code;
`ifdef FNS_ENC_RANGE_CHK_EN
  logic          out_err;
`endif

  int ntests = 0;
  int nfails = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [CW:0] sb [$];
  int wt [CW+1] = '{1, 2, 3, 5, 8, 13, 21, 34, 55};

  fns_cac_enc_seq #(.CW(CW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code)
`ifdef FNS_ENC_RANGE_CHK_EN
    ,
    .out_err   (out_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference greedy Fibonacci conversion; returns {err, code}.
  function automatic logic [CW:0] model(input int d);
    logic [CW-1:0] c;
    int r;
    c = '0;
    r = d;
`ifdef FNS_ENC_RANGE_CHK_EN
    if (d >= wt[CW]) return {1'b1, CW'(0)};
`endif
    for (int k = CW - 1; k >= 0; k--) begin
      if (r >= wt[k]) begin
        c[k] = 1'b1;
        r -= wt[k];
      end
    end
    return {1'b0, c};
  endfunction

  function automatic int fns_decode(input logic [CW-1:0] c);
    int s;
    s = 0;
    for (int k = 0; k < CW; k++) if (c[k]) s += wt[k];
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word; expc<0 selects the model. hold>0 stalls out_ready that many DONE cycles.
  task automatic send_word(input int d, input int expc, input int expe, input int hold,
                           input bit chk_period, input string tag);
    int n;
    int lat;
    int acc;
    logic [CW:0] e;
    logic [CW-1:0] held;
    in_data  = DW'(d);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    acc = cyc;
    in_valid = 1'b0;
    if (expc < 0) sb.push_back(model(d));
    else sb.push_back({expe[0], CW'(expc)});
    if (chk_period) check({tag, "_period"}, 32'(acc - last_acc), 32'(CW + 2));
    last_acc = acc;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(CW + 1));
    if (hold > 0) begin
      out_ready = 1'b0;
      held      = out_code;
      in_valid  = 1'b1;
      in_data   = DW'(7);
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bp_code"}, 32'(out_code), 32'(held));
        check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_code"}, 32'(out_code), 32'(e[CW-1:0]));
`ifdef FNS_ENC_RANGE_CHK_EN
      check({tag, "_err"}, 32'(out_err), 32'(e[CW]));
`endif
    end
    if (d < wt[CW]) begin
      check({tag, "_decode"}, 32'(fns_decode(out_code)), 32'(d));
      check({tag, "_zeck"}, 32'(out_code & (out_code >> 1)), 32'd0);
    end
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(out_code), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef FNS_ENC_RANGE_CHK_EN
    check("rst_err", 32'(out_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // Directed words with known codewords.
    send_word(0, 'h00, 0, 0, 1'b0, "d0");
    send_word(54, 'hAA, 0, 0, 1'b1, "d54");
    send_word(20, 'h2A, 0, 0, 1'b1, "d20");

    // Out-of-range input.
`ifdef FNS_ENC_RANGE_CHK_EN
    send_word(55, 'h00, 1, 0, 1'b1, "d55");
    send_word(3, -1, 0, 0, 1'b1, "err_clear");
`else
    send_word(55, 'hC0, 0, 0, 1'b1, "d55");
`endif

    // Full legal sweep, back-to-back.
    for (int v = 0; v < wt[CW]; v++) send_word(v, -1, 0, 0, 1'b1, $sformatf("sweep%0d", v));

    // Output backpressure with a competing input word.
    send_word(40, -1, 0, 5, 1'b0, "bp40");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_extra_valid", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of a conversion.
    in_data  = DW'(33);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_code", 32'(out_code), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_valid_after", 32'(out_valid), 32'd0);
    send_word(20, 'h2A, 0, 0, 1'b0, "after_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end

endmodule
